sc_statemachine_pointtype: RTL and testbench

- Controller FSM that sequences the point-type rotate register (clear / load / rotate-left / rotate-right register, DATAWIDTH bits).
- Converts active-low player buttons and a start request into the register's one-cycle command pulses: clear_InLow, load0_InLow and shiftselection.
- Tracks the current rotation index of the pattern so downstream logic (collision/score) knows the point position without decoding the register.

---
 rtl/sc_statemachine_pointtype_pkg.sv | 16 +
 rtl/sc_statemachine_pointtype_poscounter.sv | 32 +++
 rtl/sc_statemachine_pointtype.sv | 129 ++++++++++++
 tb/tb_sc_statemachine_pointtype.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sc_statemachine_pointtype_pkg.sv
// Shared definitions for the point-type rotate register controller:
// FSM state encodings and the register's shiftselection command codes.
package sc_statemachine_pointtype_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_LOAD    = 3'd2;
    localparam logic [2:0] ST_SHIFTL  = 3'd3;
    localparam logic [2:0] ST_SHIFTR  = 3'd4;
    localparam logic [2:0] ST_WAITREL = 3'd5;

    localparam logic [1:0] SHIFT_HOLD  = 2'b00;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;

endpackage

// File: rtl/sc_statemachine_pointtype_poscounter.sv
// Modulo-DATAWIDTH up/down position counter with synchronous clear.
// Clear wins over up/down; up and down together hold the value.
module sc_poscounter_mod #(
    parameter int DATAWIDTH = 8,
    parameter int POS_WIDTH = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_up,
    input  logic                 i_down,
    output logic [POS_WIDTH-1:0] o_pos
);

    localparam logic [POS_WIDTH-1:0] POS_MAX = POS_WIDTH'(DATAWIDTH - 1);

    logic [POS_WIDTH-1:0] r_pos;

    // Step the rotation index with wrap at both ends of 0..DATAWIDTH-1
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_pos <= '0;
        end else if (i_up && !i_down) begin
            r_pos <= (r_pos == POS_MAX) ? '0 : r_pos + 1'b1;
        end else if (i_down && !i_up) begin
            r_pos <= (r_pos == '0) ? POS_MAX : r_pos - 1'b1;
        end
    end

    assign o_pos = r_pos;

endmodule

// File: rtl/sc_statemachine_pointtype.sv
// Controller FSM for the point-type rotate register: turns buttons and start
// into one-cycle clear/load/shift commands. Option: SC_STATEMACHINEPOINT_AUTOROTATE_EN.
module sc_statemachine_pointtype
    import sc_statemachine_pointtype_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int POS_WIDTH = 3
) (
    input  logic                 SC_STATEMACHINEPOINT_CLOCK_50,
    input  logic                 SC_STATEMACHINEPOINT_RESET_InHigh,
    input  logic                 SC_STATEMACHINEPOINT_start_InLow,
    input  logic                 SC_STATEMACHINEPOINT_left_InLow,
    input  logic                 SC_STATEMACHINEPOINT_right_InLow,
    input  logic                 SC_STATEMACHINEPOINT_tick_In,
    output logic                 SC_STATEMACHINEPOINT_clear_OutLow,
    output logic                 SC_STATEMACHINEPOINT_load0_OutLow,
    output logic [1:0]           SC_STATEMACHINEPOINT_shiftselection_Out,
    output logic [POS_WIDTH-1:0] SC_STATEMACHINEPOINT_position_OutBUS,
    output logic                 SC_STATEMACHINEPOINT_busy_Out
);

    logic       w_clk;
    logic       w_rst;
    logic       w_start_n;
    logic       w_left_n;
    logic       w_right_n;
    logic       w_all_rel;
    logic [2:0] r_state;
    logic [2:0] w_next_state;

    assign w_clk     = SC_STATEMACHINEPOINT_CLOCK_50;
    assign w_rst     = SC_STATEMACHINEPOINT_RESET_InHigh;
    assign w_start_n = SC_STATEMACHINEPOINT_start_InLow;
    assign w_left_n  = SC_STATEMACHINEPOINT_left_InLow;
    assign w_right_n = SC_STATEMACHINEPOINT_right_InLow;
    assign w_all_rel = w_start_n & w_left_n & w_right_n;

`ifdef SC_STATEMACHINEPOINT_AUTOROTATE_EN
    logic r_auto;
    logic w_auto_next;
    logic w_tick;

    assign w_tick = SC_STATEMACHINEPOINT_tick_In;
`else
    logic w_unused_tick;

    assign w_unused_tick = SC_STATEMACHINEPOINT_tick_In;
`endif

    // Next-state selection; buttons outrank the time-base tick in IDLE
    always_comb begin
        w_next_state = r_state;
`ifdef SC_STATEMACHINEPOINT_AUTOROTATE_EN
        w_auto_next  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!w_start_n) begin
                    w_next_state = ST_CLEAR;
                end else if (!w_left_n && w_right_n) begin
                    w_next_state = ST_SHIFTL;
                end else if (!w_right_n && w_left_n) begin
                    w_next_state = ST_SHIFTR;
`ifdef SC_STATEMACHINEPOINT_AUTOROTATE_EN
                end else if (w_all_rel && w_tick) begin
                    w_next_state = ST_SHIFTL;
                    w_auto_next  = 1'b1;
`endif
                end
            end
            ST_CLEAR: w_next_state = ST_LOAD;
            ST_LOAD:  w_next_state = ST_WAITREL;
            ST_SHIFTL: begin
`ifdef SC_STATEMACHINEPOINT_AUTOROTATE_EN
                w_next_state = r_auto ? ST_IDLE : ST_WAITREL;
`else
                w_next_state = ST_WAITREL;
`endif
            end
            ST_SHIFTR: w_next_state = ST_WAITREL;
            ST_WAITREL: begin
                if (w_all_rel) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register; reset returns to IDLE from any state
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

`ifdef SC_STATEMACHINEPOINT_AUTOROTATE_EN
    // Remember that the pending SHIFTL came from the tick, not a button
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_auto <= 1'b0;
        end else begin
            r_auto <= w_auto_next;
        end
    end
`endif

    assign SC_STATEMACHINEPOINT_clear_OutLow = (r_state != ST_CLEAR);
    assign SC_STATEMACHINEPOINT_load0_OutLow = (r_state != ST_LOAD);
    assign SC_STATEMACHINEPOINT_busy_Out     = (r_state != ST_IDLE);
    assign SC_STATEMACHINEPOINT_shiftselection_Out =
        (r_state == ST_SHIFTL) ? SHIFT_LEFT  :
        (r_state == ST_SHIFTR) ? SHIFT_RIGHT : SHIFT_HOLD;

    sc_poscounter_mod #(
        .DATAWIDTH (DATAWIDTH),
        .POS_WIDTH (POS_WIDTH)
    ) u_poscounter (
        .i_clk   (w_clk),
        .i_rst   (w_rst),
        .i_clear (r_state == ST_CLEAR),
        .i_up    (r_state == ST_SHIFTL),
        .i_down  (r_state == ST_SHIFTR),
        .o_pos   (SC_STATEMACHINEPOINT_position_OutBUS)
    );

endmodule

// File: tb/tb_sc_statemachine_pointtype.sv
// Bench for sc_statemachine_pointtype: directed checks plus random stimulus
// against a command-plan model (queue of upcoming commands).
module tb_sc_statemachine_pointtype;

    localparam int DW = 8;
    localparam int PW = 3;

    localparam int P_CLR = 1;
    localparam int P_LD  = 2;
    localparam int P_L   = 3;
    localparam int P_R   = 4;
    localparam int P_W   = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_n = 1'b1;
    logic          left_n = 1'b1;
    logic          right_n = 1'b1;
    logic          tick = 1'b0;
    logic          clear_n;
    logic          load_n;
    logic [1:0]    ss;
    logic [PW-1:0] pos;
    logic          busy;

    int total = 0;
    int bad = 0;
    bit cmp_on = 1'b0;

    int q[$];
    int m_pos = 0;

    sc_statemachine_pointtype #(.DATAWIDTH(DW), .POS_WIDTH(PW)) dut (
        .SC_STATEMACHINEPOINT_CLOCK_50           (clk),
        .SC_STATEMACHINEPOINT_RESET_InHigh       (rst),
        .SC_STATEMACHINEPOINT_start_InLow        (start_n),
        .SC_STATEMACHINEPOINT_left_InLow         (left_n),
        .SC_STATEMACHINEPOINT_right_InLow        (right_n),
        .SC_STATEMACHINEPOINT_tick_In            (tick),
        .SC_STATEMACHINEPOINT_clear_OutLow       (clear_n),
        .SC_STATEMACHINEPOINT_load0_OutLow       (load_n),
        .SC_STATEMACHINEPOINT_shiftselection_Out (ss),
        .SC_STATEMACHINEPOINT_position_OutBUS    (pos),
        .SC_STATEMACHINEPOINT_busy_Out           (busy)
    );

    always #5 clk = ~clk;

    // Model: the front of q is the command shown this cycle; empty q = idle.
    always @(posedge clk) begin
        int cur;
        if (rst) begin
            q.delete();
            m_pos = 0;
        end else begin
            cur = (q.size() != 0) ? q[0] : 0;
            if (cur == P_CLR) m_pos = 0;
            if (cur == P_L)   m_pos = (m_pos + 1) % DW;
            if (cur == P_R)   m_pos = (m_pos + DW - 1) % DW;
            if (cur == 0) begin
                if (!start_n) begin
                    q.push_back(P_CLR);
                    q.push_back(P_LD);
                    q.push_back(P_W);
                end else if (!left_n && right_n) begin
                    q.push_back(P_L);
                    q.push_back(P_W);
                end else if (!right_n && left_n) begin
                    q.push_back(P_R);
                    q.push_back(P_W);
`ifdef SC_STATEMACHINEPOINT_AUTOROTATE_EN
                end else if (left_n && right_n && tick) begin
                    q.push_back(P_L);
`endif
                end
            end else if (cur == P_W) begin
                if (start_n && left_n && right_n) void'(q.pop_front());
            end else begin
                void'(q.pop_front());
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        int f;
        logic [1:0] e_ss;
        if (cmp_on) begin
            f = (q.size() != 0) ? q[0] : 0;
            e_ss = (f == P_L) ? 2'b01 : (f == P_R) ? 2'b10 : 2'b00;
            total++;
            if (clear_n !== (f != P_CLR) || load_n !== (f != P_LD) ||
                ss !== e_ss || busy !== (f != 0) || int'(pos) != m_pos) begin
                bad++;
                $display("FAIL model t=%0t got clr=%b ld=%b ss=%b busy=%b pos=%0d want clr=%b ld=%b ss=%b busy=%b pos=%0d",
                         $time, clear_n, load_n, ss, busy, pos,
                         f != P_CLR, f != P_LD, e_ss, f != 0, m_pos);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    initial begin
        int n;
        cyc(2);
        rst = 1'b0;
        cmp_on = 1'b1;
        cyc(1);
        chk("rst_pos", int'(pos), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_clr", int'(clear_n), 1);
        chk("rst_ld", int'(load_n), 1);
        chk("rst_ss", int'(ss), 0);

        start_n = 1'b0;
        cyc(1);
        chk("start_clr", int'(clear_n), 0);
        start_n = 1'b1;
        cyc(1);
        chk("start_ld", int'(load_n), 0);
        cyc(1);
        chk("start_wait_busy", int'(busy), 1);
        cyc(1);
        chk("start_idle_busy", int'(busy), 0);
        chk("start_pos", int'(pos), 0);

        start_n = 1'b0;
        cyc(1);
        start_n = 1'b1;
        cyc(1);
        chk("mid_load", int'(load_n), 0);
        rst = 1'b1;
        cyc(1);
        chk("rst_in_load_busy", int'(busy), 0);
        rst = 1'b0;
        cyc(1);

        right_n = 1'b0;
        cyc(1);
        chk("right_ss", int'(ss), 2);
        right_n = 1'b1;
        cyc(2);
        chk("right_pos", int'(pos), 7);

        left_n = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (ss == 2'b01) n++;
        end
        left_n = 1'b1;
        cyc(2);
        chk("left_hold_pulses", n, 1);
        chk("left_wrap_pos", int'(pos), 0);

        left_n = 1'b0;
        right_n = 1'b0;
        cyc(3);
        chk("both_busy", int'(busy), 0);
        left_n = 1'b1;
        right_n = 1'b1;
        cyc(1);

        n = 0;
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            cyc(1);
            if (ss == 2'b01) n++;
            tick = 1'b0;
            for (int j = 0; j < 3; j++) begin
                cyc(1);
                if (ss == 2'b01) n++;
            end
        end
`ifdef SC_STATEMACHINEPOINT_AUTOROTATE_EN
        chk("tick_pulses", n, 3);
        chk("tick_pos", int'(pos), 3);
        tick = 1'b1;
        right_n = 1'b0;
        cyc(1);
        chk("tick_vs_right", int'(ss), 2);
        tick = 1'b0;
        right_n = 1'b1;
        cyc(2);
        chk("tick_vs_right_pos", int'(pos), 2);
`else
        chk("tick_pulses", n, 0);
        chk("tick_pos", int'(pos), 0);
`endif

        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(63) == 0);
            start_n = ($urandom_range(9) != 0);
            left_n  = ($urandom_range(3) != 0);
            right_n = ($urandom_range(3) != 0);
            tick    = ($urandom_range(4) == 0);
            cyc(1);
        end

        cmp_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
